sum_seq_ctrl: RTL

- Multi-word add sequencer. Adds two wide operands (NUM_WORD words of SIZE_DATA bits) using a single internal SUM_unit of width SIZE_DATA, one word per cycle, least-significant word first.
- Carry is chained through a register between words.
- Sits between the mantissa/extended-precision datapath and the shared adder. Valid/ready on both sides.

---
 rtl/sum_seq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: multi-word add sequencer.
// Adds two NUM_WORD x SIZE_DATA operands one word per cycle through a single
// SIZE_DATA-wide adder, least-significant word first. The carry between words
// is chained through a register.
// Optional feature macro: SUM_SEQ_SUB_EN (adds i_sub for A-B subtraction).
module sum_seq_ctrl #(
    parameter int SIZE_DATA = 25,
    parameter int NUM_WORD  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [NUM_WORD*SIZE_DATA-1:0] i_data_a,
    input  logic [NUM_WORD*SIZE_DATA-1:0] i_data_b,
    input  logic                          i_carry,
`ifdef SUM_SEQ_SUB_EN
    input  logic                          i_sub,
`endif
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [NUM_WORD*SIZE_DATA-1:0] o_sum,
    output logic                          o_carry
);

    localparam int TOTAL_W = NUM_WORD * SIZE_DATA;
    localparam int CNT_W   = (NUM_WORD > 1) ? $clog2(NUM_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TOTAL_W-1:0]   a_reg;
    logic [TOTAL_W-1:0]   b_reg;
    logic                 carry_reg;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 last_word;
    logic [TOTAL_W-1:0]   b_load;
    logic                 carry_load;
    logic [SIZE_DATA-1:0] word_a;
    logic [SIZE_DATA-1:0] word_b;
    logic [SIZE_DATA-1:0] word_sum;
    logic                 word_carry;

    // Handshake flags come straight from the state register, so neither
    // o_ready nor o_valid has a combinational path from i_valid or i_ready.
    assign o_ready   = (state == IDLE);
    assign o_valid   = (state == DONE);
    assign accept    = i_valid & o_ready;
    assign last_word = (cnt == LAST_WORD);

`ifdef SUM_SEQ_SUB_EN
    // Subtraction is A + ~B + 1, so B is inverted and the carry forced at accept.
    always_comb begin
        b_load     = i_sub ? ~i_data_b : i_data_b;
        carry_load = i_sub | i_carry;
    end
`else
    // Addition only: operands are latched unmodified.
    always_comb begin
        b_load     = i_data_b;
        carry_load = i_carry;
    end
`endif

    // The shared SUM_unit: one word of A and B plus the chained carry.
    always_comb begin
        word_a = a_reg[cnt*SIZE_DATA +: SIZE_DATA];
        word_b = b_reg[cnt*SIZE_DATA +: SIZE_DATA];
        {word_carry, word_sum} = {1'b0, word_a} + {1'b0, word_b}
                                 + {{SIZE_DATA{1'b0}}, carry_reg};
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, walk the words in RUN, wait in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands at accept, then write one result word per RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            o_sum     <= '0;
            o_carry   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= i_data_a;
                        b_reg     <= b_load;
                        carry_reg <= carry_load;
                        o_sum     <= '0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    o_sum[cnt*SIZE_DATA +: SIZE_DATA] <= word_sum;
                    carry_reg <= word_carry;
                    cnt       <= cnt + 1'b1;
                    if (last_word) begin
                        o_carry <= word_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
